// File: rtl/snake_body_ctrl_if.sv
// ---------------------------------------------------------------------------
// snake_body_ctrl_if
// Bundles the game-control, apple, pixel-scan and status signals of
// snake_body_ctrl so the engine and its neighbours connect through one port.
//
// Signals (direction seen from the engine, modport slave):
//   move_tick   in   one-cycle pulse, advance the snake by one cell
//   game_start  in   one-cycle pulse, (re)initialise and start play
//   dir_in      in   requested direction: 00 up, 01 down, 10 left, 11 right
//   apple_x     in   apple cell column 0..39
//   apple_y     in   apple cell row 0..29
//   x_pos       in   current pixel column from the display stage
//   y_pos       in   current pixel row from the display stage
//   snake       out  registered cell code: 00 none, 01 head, 10 body, 11 wall
//   apple_eaten out  one-cycle pulse when the head lands on the apple
//   game_over   out  high while the engine is in DEAD
//   length      out  current segment count
//   dbg_state   out  FSM state (00 IDLE, 01 RUN, 10 STEP, 11 DEAD)
//
// No valid/ready handshake is involved: move_tick and game_start are
// single-cycle strobes sampled on the rising clock edge, every other input
// is a level sampled on the same edge, and every output is a registered or
// state-decoded level.
// ---------------------------------------------------------------------------
interface snake_body_ctrl_if #(
    parameter int LW = 5
);
    logic          move_tick;
    logic          game_start;
    logic [1:0]    dir_in;
    logic [5:0]    apple_x;
    logic [4:0]    apple_y;
    logic [9:0]    x_pos;
    logic [9:0]    y_pos;
    logic [1:0]    snake;
    logic          apple_eaten;
    logic          game_over;
    logic [LW-1:0] length;
    logic [1:0]    dbg_state;

    // Driver side: game logic / display stage / testbench.
    modport master (
        output move_tick, game_start, dir_in, apple_x, apple_y, x_pos, y_pos,
        input  snake, apple_eaten, game_over, length, dbg_state
    );

    // Engine side.
    modport slave (
        input  move_tick, game_start, dir_in, apple_x, apple_y, x_pos, y_pos,
        output snake, apple_eaten, game_over, length, dbg_state
    );
endinterface

// File: rtl/snake_body_ctrl.sv
// ---------------------------------------------------------------------------
// snake_body_ctrl
// Game-state engine for the snake. Holds up to MAX_LEN segment coordinates
// on the 40x30 grid of 16x16-pixel cells, advances the snake on each move
// tick, grows it when the head reaches the apple, detects wall and self
// collisions, and renders the 2-bit cell code for the pixel currently
// presented by the display stage (one cycle of latency).
//
// Ports:
//   clk  in  system clock (same domain as the display stage)
//   rst  in  asynchronous active-low reset
//   bus  snake_body_ctrl_if.slave - see the interface file for signals
//
// Parameters:
//   MAX_LEN   maximum segment count, head included (4..64)
//   INIT_LEN  segment count after reset or restart (2..MAX_LEN)
//   LW        width of length, 2^LW > MAX_LEN
// ---------------------------------------------------------------------------
module snake_body_ctrl #(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3,
    parameter int LW       = 5
) (
    input  logic               clk,
    input  logic               rst,
    snake_body_ctrl_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_STEP = 2'd2;
    localparam logic [1:0] S_DEAD = 2'd3;

    localparam logic [1:0] D_UP    = 2'b00;
    localparam logic [1:0] D_DOWN  = 2'b01;
    localparam logic [1:0] D_LEFT  = 2'b10;
    localparam logic [1:0] D_RIGHT = 2'b11;

    localparam logic [5:0] HEAD_X0 = 6'd20;
    localparam logic [4:0] HEAD_Y0 = 5'd15;

    logic [1:0]    r_state;
    logic [1:0]    r_dir;
    logic [5:0]    r_seg_x [MAX_LEN];
    logic [4:0]    r_seg_y [MAX_LEN];
    logic [LW-1:0] r_len;
    logic [5:0]    r_next_x;
    logic [4:0]    r_next_y;
    logic          r_apple_eaten;
    logic [1:0]    r_snake;

    logic          w_reverse;
    logic [1:0]    w_new_dir;
    logic [5:0]    w_cand_x;
    logic [4:0]    w_cand_y;
    logic          w_wall;
    logic          w_eat;
    logic          w_self;
    logic          w_die;
    logic [5:0]    w_cx;
    logic [4:0]    w_cy;
    logic          w_on_grid;
    logic          w_wall_cell;
    logic          w_head_cell;
    logic          w_body_cell;
    logic [1:0]    w_code;
    logic          w_unused_pix;

    // Direction pairs differ only in bit 0, so a reverse request has the
    // same bit 1 and the opposite bit 0 of the current direction.
    assign w_reverse = (bus.dir_in[1] == r_dir[1]) && (bus.dir_in[0] != r_dir[0]);
    assign w_new_dir = w_reverse ? r_dir : bus.dir_in;

    // The head never sits on a wall cell, so +/-1 cannot wrap.
    always_comb begin
        w_cand_x = r_seg_x[0];
        w_cand_y = r_seg_y[0];
        case (w_new_dir)
            D_UP:    w_cand_y = r_seg_y[0] - 5'd1;
            D_DOWN:  w_cand_y = r_seg_y[0] + 5'd1;
            D_LEFT:  w_cand_x = r_seg_x[0] - 6'd1;
            D_RIGHT: w_cand_x = r_seg_x[0] + 6'd1;
            default: ;
        endcase
    end

    // Collision / eat evaluation on the head latched at the move tick.
    assign w_wall = (r_next_x == 6'd0) || (r_next_x == 6'd39) ||
                    (r_next_y == 5'd0) || (r_next_y == 5'd29);
    assign w_eat  = (r_next_x == bus.apple_x) && (r_next_y == bus.apple_y);

    // Without an eat the tail moves away this step, so it cannot be hit.
    always_comb begin
        w_self = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((i < int'(r_len)) && (w_eat || (i != int'(r_len) - 1)) &&
                (r_seg_x[i] == r_next_x) && (r_seg_y[i] == r_next_y)) begin
                w_self = 1'b1;
            end
        end
    end

    assign w_die = w_wall || w_self;

    // Pixel to cell mapping and rendering.
    assign w_cx         = bus.x_pos[9:4];
    assign w_cy         = bus.y_pos[8:4];
    assign w_unused_pix = ^{bus.x_pos[3:0], bus.y_pos[9], bus.y_pos[3:0]};
    assign w_on_grid    = (w_cx < 6'd40) && (w_cy < 5'd30);
    assign w_wall_cell  = (w_cx == 6'd0) || (w_cx == 6'd39) ||
                          (w_cy == 5'd0) || (w_cy == 5'd29);
    assign w_head_cell  = (r_seg_x[0] == w_cx) && (r_seg_y[0] == w_cy);

    always_comb begin
        w_body_cell = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if ((i < int'(r_len)) && (r_seg_x[i] == w_cx) && (r_seg_y[i] == w_cy)) begin
                w_body_cell = 1'b1;
            end
        end
    end

    always_comb begin
        w_code = 2'b00;
        if (!w_on_grid)       w_code = 2'b00;
        else if (w_wall_cell) w_code = 2'b11;
        else if (w_head_cell) w_code = 2'b01;
        else if (w_body_cell) w_code = 2'b10;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_dir         <= D_RIGHT;
            r_len         <= LW'(INIT_LEN);
            r_next_x      <= 6'd0;
            r_next_y      <= 5'd0;
            r_apple_eaten <= 1'b0;
            r_snake       <= 2'b00;
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= HEAD_X0 - 6'(i);
                r_seg_y[i] <= HEAD_Y0;
            end
        end else begin
            r_snake       <= w_code;
            r_apple_eaten <= 1'b0;
            if (bus.game_start) begin
                // Restart wins over any in-flight step, in every state.
                r_state <= S_RUN;
                r_dir   <= D_RIGHT;
                r_len   <= LW'(INIT_LEN);
                for (int i = 0; i < MAX_LEN; i++) begin
                    r_seg_x[i] <= HEAD_X0 - 6'(i);
                    r_seg_y[i] <= HEAD_Y0;
                end
            end else begin
                case (r_state)
                    S_RUN: begin
                        if (bus.move_tick) begin
                            r_dir    <= w_new_dir;
                            r_next_x <= w_cand_x;
                            r_next_y <= w_cand_y;
                            r_state  <= S_STEP;
                        end
                    end
                    S_STEP: begin
                        if (w_die) begin
                            r_state <= S_DEAD;
                        end else begin
                            // Shift covers every slot so a grown tail
                            // inherits the old tail position.
                            for (int i = MAX_LEN - 1; i >= 1; i--) begin
                                r_seg_x[i] <= r_seg_x[i-1];
                                r_seg_y[i] <= r_seg_y[i-1];
                            end
                            r_seg_x[0] <= r_next_x;
                            r_seg_y[0] <= r_next_y;
                            if (w_eat) begin
                                r_apple_eaten <= 1'b1;
                                if (int'(r_len) < MAX_LEN) begin
                                    r_len <= r_len + LW'(1);
                                end
                            end
                            r_state <= S_RUN;
                        end
                    end
                    default: ;  // IDLE and DEAD wait for game_start
                endcase
            end
        end
    end

    assign bus.snake       = r_snake;
    assign bus.apple_eaten = r_apple_eaten;
    assign bus.game_over   = (r_state == S_DEAD);
    assign bus.length      = r_len;
    assign bus.dbg_state   = r_state;

endmodule
